// File: rtl/rr_mux.sv
// N-channel round-robin arbitrating mux with a one-entry registered output and valid/ready on every port.
// Define RR_MUX_LOCK_EN to add in_last and hold the grant on one channel until the end of its packet.
module rr_mux #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
`ifdef RR_MUX_LOCK_EN
  input  logic [N-1:0]       in_last,
`endif
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  logic [SELW-1:0] ptr, gnt, nxt;
  logic [SELW:0]   idx;
  logic            gnt_vld, load_ok, accept;
`ifdef RR_MUX_LOCK_EN
  logic            locked;
  logic [SELW-1:0] lock_ch;
`endif

  // Walk the search order backwards so the channel closest to ptr is written last and wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (SELW+1)'(k);
      if (idx >= (SELW+1)'(N)) idx = idx - (SELW+1)'(N);
      if (in_valid[idx[SELW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = idx[SELW-1:0];
      end
    end
`ifdef RR_MUX_LOCK_EN
    if (locked) begin
      gnt_vld = in_valid[lock_ch];
      gnt     = lock_ch;
    end
`endif
  end

  // Gating with rst_n keeps in_ready low while reset is held.
  assign load_ok = rst_n & (~out_valid | out_ready);
  assign accept  = gnt_vld & load_ok;
  assign nxt     = (gnt == SELW'(N-1)) ? '0 : gnt + SELW'(1);

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
`ifdef RR_MUX_LOCK_EN
      locked    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gnt*WIDTH +: WIDTH];
      out_sel   <= gnt;
`ifdef RR_MUX_LOCK_EN
      if (in_last[gnt]) begin
        locked <= 1'b0;
        ptr    <= nxt;
      end else begin
        locked  <= 1'b1;
        lock_ch <= gnt;
      end
`else
      ptr       <= nxt;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux.sv
// Bench for rr_mux: directed vector table, corner sequences, and a randomized run against a queue-level model.
module tb_rr_mux;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   in_valid, in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;

  logic [2:0]     v3, r3;
  logic [23:0]    d3;
  logic           ov3;
  logic [7:0]     od3;
  logic [1:0]     os3;
`ifdef RR_MUX_LOCK_EN
  logic [N-1:0]   in_last;
  logic [2:0]     l3;
`endif

  rr_mux #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
`ifdef RR_MUX_LOCK_EN
    .in_last(in_last),
`endif
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  rr_mux #(.N(3), .WIDTH(8)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3),
`ifdef RR_MUX_LOCK_EN
    .in_last(l3),
`endif
    .in_ready(r3), .out_valid(ov3), .out_data(od3),
    .out_sel(os3), .out_ready(1'b1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] v;
    logic       ordy;
    logic [3:0] rdy;
    logic       vld;
    logic [1:0] sel;
  } vec_t;
  vec_t tbl[19];

  // reference model state
  bit          mv;
  logic [W-1:0] md;
  int          ms, mptr, g;
  bit          pend[N];
  logic [W-1:0] pdat[N];
  bit          plast[N];
  bit          mlock, lok;
  int          mlch;
  logic [N-1:0] exp_rdy;

  initial begin
    v3 = '0;
    d3 = {8'hC2, 8'hC1, 8'hC0};
`ifdef RR_MUX_LOCK_EN
    in_last = '1;
    l3 = '1;
`endif
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA0 + 32'(i);
    in_valid = '1;
    out_ready = 1'b1;

    // reset held with every channel requesting
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("rst_hold_out_valid", out_valid, 0);
    @(negedge clk); in_valid = '0;
    @(negedge clk); rst_n = 1'b1;

    // rotation, sparse wrap, backpressure, idle
    for (int k = 0; k < 8; k++) tbl[k] = '{4'hF, 1'b1, 4'(1 << (k % 4)), 1'b1, 2'(k % 4)};
    tbl[8]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[9]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[10] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
    for (int k = 11; k < 14; k++) tbl[k] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[14] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[17] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0};
    tbl[18] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0};
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      in_valid = tbl[i].v;
      out_ready = tbl[i].ordy;
      #1 chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].rdy);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].vld);
      if (tbl[i].vld) begin
        chk($sformatf("vec%0d_out_sel", i), out_sel, tbl[i].sel);
        chk($sformatf("vec%0d_out_data", i), out_data, 32'hA0 + 32'(tbl[i].sel));
      end
    end

    // async reset between edges with a beat held and ptr at 1
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_data", out_data, 0);
    chk("async_rst_in_ready", in_ready, 0);
    in_valid = '1;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 4'b0001);
    @(posedge clk); #1;
    chk("post_rst_out_sel", out_sel, 0);
    chk("post_rst_out_data", out_data, 32'hA0);

    // N=3: grant to channel 2 must wrap ptr to 0
    @(negedge clk); in_valid = '0; v3 = 3'b100;
    #1 chk("n3_in_ready_a", r3, 3'b100);
    @(posedge clk); #1 chk("n3_out_sel_a", os3, 2);
    @(negedge clk); v3 = 3'b111;
    #1 chk("n3_in_ready_b", r3, 3'b001);
    @(posedge clk); #1;
    chk("n3_out_sel_b", os3, 0);
    chk("n3_out_data_b", od3, 8'hC0);
    @(negedge clk); v3 = '0;

`ifdef RR_MUX_LOCK_EN
    // channel 1 three-beat packet while channel 2 keeps requesting
    @(negedge clk); rst_n = 1'b0; in_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = (k < 3) ? 4'b0110 : 4'b0100;
      in_last  = (k == 2) ? 4'b1111 : 4'b1101;
      @(posedge clk); #1;
      chk($sformatf("lock_out_sel%0d", k), out_sel, (k < 3) ? 1 : 2);
    end
`endif

    // randomized run against the model
    @(negedge clk); rst_n = 1'b0; in_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    mv = 0; md = '0; ms = 0; mptr = 0; mlock = 0; mlch = 0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; pdat[i] = '0; plast[i] = 1; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          pdat[i] = $urandom;
          plast[i] = ($urandom_range(0, 2) != 0);
        end
        in_valid[i] = pend[i];
        in_data[i*W +: W] = pdat[i];
`ifdef RR_MUX_LOCK_EN
        in_last[i] = plast[i];
`endif
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (mptr + k) % N;
        if (g < 0 && pend[c] && (!mlock || c == mlch)) g = c;
      end
      lok = !mv || out_ready;
      exp_rdy = '0;
      if (lok && g >= 0) exp_rdy[g] = 1'b1;
      chk("rand_in_ready", in_ready, exp_rdy);
      if (lok && g >= 0) begin
        mv = 1; md = pdat[g]; ms = g; pend[g] = 0;
`ifdef RR_MUX_LOCK_EN
        if (plast[g]) begin mlock = 0; mptr = (g + 1) % N; end
        else begin mlock = 1; mlch = g; end
`else
        mptr = (g + 1) % N;
`endif
      end else if (out_ready) begin
        mv = 0;
      end
      @(posedge clk); #1;
      chk("rand_out_valid", out_valid, mv);
      if (mv) begin
        chk("rand_out_data", out_data, md);
        chk("rand_out_sel", out_sel, 64'(ms));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rr_mux.md
# rr_mux

Parametrised N-channel, WIDTH-bit round-robin arbitrating multiplexer with a registered output stage and valid/ready handshakes on every port. Generalises the single-bit 2:1 combinational mux to an arbitrated, buffered channel selector. Used in the single-cycle core's surroundings where several requesters (fetch, load/store, debug) share one downstream port such as the memory interface.

## Interface
- `N`, 4, number of input channels; legal range 2..16.
- `WIDTH`, 32, data width per channel.
- `SELW`, `$clog2(N)`, width of the channel index; derived, not overridden.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `in_valid`  input  N  request per channel.
- `in_data`  input  N*WIDTH  flattened data; channel i occupies `[i*WIDTH +: WIDTH]`.
- `in_ready`  output  N  accept per channel; at most one bit high in any cycle.
- `out_valid`  output  1  output register holds a beat.
- `out_data`  output  WIDTH  registered data of the accepted beat.
- `out_sel`  output  SELW  index of the channel that supplied `out_data`.
- `out_ready`  input  1  downstream accept.
- `in_last`  input  N  end-of-packet marker; present only with `RR_MUX_LOCK_EN`.

One clock; reset is asynchronous and active-low (`clk`, `rst_n`).

## Operation
- State: round-robin pointer `ptr` (SELW bits), one-entry output register (`out_valid`, `out_data`, `out_sel`), lock state when `RR_MUX_LOCK_EN` is set.
- Output register can load when `load_ok = !out_valid || out_ready`.
- Grant, combinational: the first channel with `in_valid` high, searching `ptr, ptr+1, ..., N-1, 0, ..., ptr-1`. No valid input means no grant.
- `in_ready[g] = load_ok` for the granted channel g; all other bits are 0. `in_ready` may depend combinationally on `in_valid` and `out_ready`.
- Accept: `in_valid[g] && in_ready[g]`. At the next edge the register loads `in_data[g]`, sets `out_sel = g` and `out_valid = 1`, and updates `ptr` to `(g+1) mod N`. Wrap is explicit; N need not be a power of two.
- No accept while `load_ok` is high: `out_valid` clears if `out_ready` is high, and `ptr` is unchanged.
- `out_valid && !out_ready`: the register holds and all `in_ready` bits are 0 (backpressure). `ptr` is unchanged.
- Simultaneous drain and fill (`out_valid && out_ready` plus a new accept): the new beat replaces the old one with no bubble. Full throughput is one beat per cycle.
- Inputs follow the valid/ready rule: once `in_valid` is raised, it and the data stay stable until accepted. The block does not check this.

## Timing
- Latency is 1 cycle from input accept to `out_valid`.
- Reset values: `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`, unlocked. `in_ready` is therefore all 0 until the first valid input arrives after reset.
- Reset asserted mid-operation discards any held beat immediately, asynchronously. After `rst_n` rises, the first grant searches from channel 0.
- Fairness: with all N channels continuously valid and `out_ready=1`, the grant order is 0,1,...,N-1,0,... Each channel waits at most N-1 beats.

## Configuration
- `RR_MUX_LOCK_EN` defined:
  - Adds the `in_last` port.
  - After a beat is accepted from channel g with `in_last[g]=0`, the grant is locked to g, ignoring other `in_valid` bits, until a beat with `in_last[g]=1` is accepted.
  - `ptr` advances only on the last beat.
  - Reset clears the lock.
- `RR_MUX_LOCK_EN` undefined:
  - No `in_last` port.
  - Arbitration is per beat, as described above.

## Test plan
- Reset and idle:
  - Stimulus: hold `rst_n=0` with all `in_valid=1`.
  - Required: `out_valid=0`, `out_data=0`, `in_ready=0`.
  - After release, the first beat comes from channel 0.
- Fair rotation:
  - Stimulus: N=4, all channels valid with data 0xA0..0xA3, `out_ready=1` for 8 cycles.
  - Required: `out_sel` sequence 0,1,2,3,0,1,2,3 with the matching data, `out_valid` high every cycle from cycle 1.
- Sparse request and wrap:
  - Stimulus: `ptr=3`, only channels 1 and 3 valid.
  - Required: channel 3 granted first, then channel 1.
  - Also: with N=3, after a grant to channel 2, `ptr` becomes 0.
- Backpressure:
  - Stimulus: `out_ready=0` for 3 cycles with `out_valid=1`.
  - Required: `out_data` and `out_sel` hold, `in_ready=0`.
  - When `out_ready` returns to 1, the next beat loads in the same cycle.
- Async reset mid-stream:
  - Stimulus: drop `rst_n` between edges while `out_valid=1`.
  - Required: `out_valid` goes to 0 without a clock edge, and `ptr` returns to 0.
- Lock (`RR_MUX_LOCK_EN`):
  - Stimulus: channel 1 sends 3 beats with `in_last` only on the third, while channel 2 is continuously valid.
  - Required: `out_sel` sequence 1,1,1,2.
